// File: rtl/fp_pkg.sv
// Shared types and field helpers for the sequential FP mul/div unit
// and the rounding/packing stage it shares with the adder.
package fp_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_UNPACK,
    S_MUL_IT,
    S_DIV_IT,
    S_NORM,
    S_ROUND,
    S_DONE
  } state_t;

  localparam logic [1:0] OFUF_OK = 2'b00;
  localparam logic [1:0] OFUF_OV = 2'b10;
  localparam logic [1:0] OFUF_UF = 2'b01;

  function automatic int fp_bias(input int ew);
    return (1 << (ew - 1)) - 1;
  endfunction

  function automatic int fp_exp_ones(input int ew);
    return (1 << ew) - 1;
  endfunction

  function automatic int fp_inf(input int ew, input int mw,
                                input logic s);
    return (int'(s) << (ew + mw)) | (fp_exp_ones(ew) << mw);
  endfunction

  function automatic int fp_nan(input int ew, input int mw,
                                input logic s);
    return fp_inf(ew, mw, s) | (1 << (mw - 1));
  endfunction

endpackage

// File: rtl/fp_round_pack.sv
// Round-to-nearest-even on a normalised significand, then range
// check the exponent and pack sign/exp/fraction with OFUF flags.
module fp_round_pack
  import fp_pkg::*;
#(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10
) (
  input  logic                     i_sign,
  input  logic signed [EXP_W+1:0]  i_e,
  input  logic [MAN_W:0]           i_sig,
  input  logic                     i_g,
  input  logic                     i_r,
  input  logic                     i_s,
  output logic [EXP_W+MAN_W:0]     o_res,
  output logic [1:0]               o_ofuf
);

  localparam int W = 1 + EXP_W + MAN_W;
  localparam logic signed [EXP_W+1:0] EMAX =
    (EXP_W+2)'(fp_exp_ones(EXP_W));

  logic                    w_inc;
  logic [MAN_W+1:0]        w_sum;
  logic [MAN_W-1:0]        w_frac;
  logic signed [EXP_W+1:0] w_e;

  assign w_inc  = i_g & (i_r | i_s | i_sig[0]);
  assign w_sum  = {1'b0, i_sig} + {{(MAN_W+1){1'b0}}, w_inc};
  // Carry-out only happens from all-ones, so fraction is zero.
  assign w_frac = w_sum[MAN_W+1] ? w_sum[MAN_W:1]
                                 : w_sum[MAN_W-1:0];
  assign w_e    = i_e + {{(EXP_W+1){1'b0}}, w_sum[MAN_W+1]};

  always_comb begin
    o_res  = {i_sign, w_e[EXP_W-1:0], w_frac};
    o_ofuf = OFUF_OK;
    if (w_e >= EMAX) begin
      o_res  = W'(fp_inf(EXP_W, MAN_W, i_sign));
      o_ofuf = OFUF_OV;
    end else if (w_e[EXP_W+1] || w_e == '0) begin
      o_res  = {i_sign, {(W-1){1'b0}}};
      o_ofuf = OFUF_UF;
    end
  end

endmodule

// File: rtl/fp_mul_div_seq.sv
// Iterative FP multiply (shift-add) / divide (restoring) unit with
// round-to-nearest-even and OFUF reporting; one op per handshake.
module fp_mul_div_seq
  import fp_pkg::*;
#(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 mul_div,
  input  logic [EXP_W+MAN_W:0] x,
  input  logic [EXP_W+MAN_W:0] y,
  output logic                 busy,
  output logic                 done,
  output logic [EXP_W+MAN_W:0] result,
  output logic [1:0]           ofuf
);

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int SW = MAN_W + 1;
  localparam int PW = 2 * SW;
  localparam int QW = MAN_W + 3;
  localparam int EW = EXP_W + 2;
  localparam int CW = $clog2(QW);

  localparam logic [EXP_W-1:0] EONES =
    EXP_W'(fp_exp_ones(EXP_W));
  localparam logic signed [EW-1:0] BIAS_E =
    EW'(fp_bias(EXP_W));
  localparam logic [CW-1:0] CNT_MUL = CW'(SW - 2);
  localparam logic [CW-1:0] CNT_DIV = CW'(QW - 2);

  state_t r_state, w_nxt;

  logic              r_op;
  logic [W-1:0]      r_x, r_y;
  logic [PW-1:0]     r_prod;
  logic [SW:0]       r_rem;
  logic [QW-1:0]     r_quo;
  logic [CW-1:0]     r_cnt;
  logic signed [EW-1:0] r_e;
  logic [MAN_W:0]    r_sig;
  logic              r_g, r_r, r_s;
  logic [W-1:0]      r_pack, r_res;
  logic [1:0]        r_pk_of, r_of;
  logic              r_done;

  logic [SW-1:0]     w_sx, w_sy;
  logic [EXP_W-1:0]  w_ex, w_ey;
  logic signed [EW-1:0] w_ex_s, w_ey_s;
  logic              w_sgn, w_xz, w_yz, w_xinf, w_yinf;
  logic              w_unp;
  logic [PW-1:0]     w_prod_cur, w_prod_nxt;
  logic [SW:0]       w_pp;
  logic [SW:0]       w_rem_cur, w_rsub, w_rem_nxt;
  logic              w_ge;
  logic [QW-1:0]     w_quo_nxt;
  logic              w_special;
  logic [W-1:0]      w_sp_res, w_rp_res;
  logic [1:0]        w_sp_of, w_rp_of;
  logic [MAN_W:0]    w_n_sig;
  logic              w_n_g, w_n_r, w_n_s;
  logic signed [EW-1:0] w_n_adj;

  assign w_ex   = r_x[W-2:MAN_W];
  assign w_ey   = r_y[W-2:MAN_W];
  assign w_ex_s = {2'b00, w_ex};
  assign w_ey_s = {2'b00, w_ey};
  assign w_sx   = {1'b1, r_x[MAN_W-1:0]};
  assign w_sy   = {1'b1, r_y[MAN_W-1:0]};
  assign w_sgn  = r_x[W-1] ^ r_y[W-1];
  assign w_xz   = (w_ex == '0);
  assign w_yz   = (w_ey == '0);
  assign w_xinf = (w_ex == EONES);
  assign w_yinf = (w_ey == EONES);
  assign w_unp  = (r_state == S_UNPACK);

  // UNPACK performs the first iteration from the raw significands.
  assign w_prod_cur = w_unp ? {{SW{1'b0}}, w_sy} : r_prod;
  assign w_pp       = {1'b0, w_prod_cur[PW-1:SW]} +
                      (w_prod_cur[0] ? {1'b0, w_sx} : '0);
  assign w_prod_nxt = {w_pp, w_prod_cur[SW-1:1]};

  assign w_rem_cur = w_unp ? {1'b0, w_sx} : r_rem;
  assign w_ge      = (w_rem_cur >= {1'b0, w_sy});
  assign w_rsub    = w_ge ? w_rem_cur - {1'b0, w_sy} : w_rem_cur;
  assign w_rem_nxt = w_rsub << 1;
  assign w_quo_nxt = w_unp ? {{(QW-1){1'b0}}, w_ge}
                           : {r_quo[QW-2:0], w_ge};

  always_comb begin
    w_special = 1'b1;
    w_sp_res  = {w_sgn, {(W-1){1'b0}}};
    w_sp_of   = OFUF_OK;
    if (w_xinf || w_yinf) begin
      w_sp_res = W'(fp_inf(EXP_W, MAN_W, w_sgn));
      w_sp_of  = OFUF_OV;
    end else if (r_op && w_xz && w_yz) begin
      w_sp_res = W'(fp_nan(EXP_W, MAN_W, w_sgn));
      w_sp_of  = OFUF_OV;
    end else if (r_op && w_yz) begin
      w_sp_res = W'(fp_inf(EXP_W, MAN_W, w_sgn));
      w_sp_of  = OFUF_OV;
    end else if (!(w_xz || w_yz)) begin
      w_special = 1'b0;
    end
  end

  always_comb begin
    w_n_sig = r_prod[PW-2 -: SW];
    w_n_g   = r_prod[SW-2];
    w_n_r   = r_prod[SW-3];
    w_n_s   = |r_prod[SW-4:0];
    w_n_adj = '0;
    if (!r_op) begin
      if (r_prod[PW-1]) begin
        w_n_sig = r_prod[PW-1 -: SW];
        w_n_g   = r_prod[SW-1];
        w_n_r   = r_prod[SW-2];
        w_n_s   = |r_prod[SW-3:0];
        w_n_adj = EW'(1);
      end
    end else begin
      w_n_s = |r_rem;
      if (r_quo[QW-1]) begin
        w_n_sig = r_quo[QW-1 -: SW];
        w_n_g   = r_quo[1];
        w_n_r   = r_quo[0];
      end else begin
        w_n_sig = r_quo[QW-2 -: SW];
        w_n_g   = r_quo[0];
        w_n_r   = 1'b0;
        w_n_adj = '1;
      end
    end
  end

  fp_round_pack #(
    .EXP_W (EXP_W),
    .MAN_W (MAN_W)
  ) u_round_pack (
    .i_sign (w_sgn),
    .i_e    (r_e),
    .i_sig  (r_sig),
    .i_g    (r_g),
    .i_r    (r_r),
    .i_s    (r_s),
    .o_res  (w_rp_res),
    .o_ofuf (w_rp_of)
  );

  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      S_IDLE:   if (start) w_nxt = S_UNPACK;
      S_UNPACK: begin
        if (w_special)  w_nxt = S_DONE;
        else if (r_op)  w_nxt = S_DIV_IT;
        else            w_nxt = S_MUL_IT;
      end
      S_MUL_IT,
      S_DIV_IT: if (r_cnt == '0) w_nxt = S_NORM;
      S_NORM:   w_nxt = S_ROUND;
      S_ROUND:  w_nxt = S_DONE;
      S_DONE:   w_nxt = S_IDLE;
      default:  w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_nxt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_op    <= 1'b0;
      r_x     <= '0;
      r_y     <= '0;
      r_prod  <= '0;
      r_rem   <= '0;
      r_quo   <= '0;
      r_cnt   <= '0;
      r_e     <= '0;
      r_sig   <= '0;
      r_g     <= 1'b0;
      r_r     <= 1'b0;
      r_s     <= 1'b0;
      r_pack  <= '0;
      r_pk_of <= OFUF_OK;
      r_res   <= '0;
      r_of    <= OFUF_OK;
      r_done  <= 1'b0;
    end else begin
      r_done <= (r_state == S_DONE);
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_op <= mul_div;
            r_x  <= x;
            r_y  <= y;
          end
        end
        S_UNPACK: begin
          r_prod  <= w_prod_nxt;
          r_rem   <= w_rem_nxt;
          r_quo   <= w_quo_nxt;
          r_cnt   <= r_op ? CNT_DIV : CNT_MUL;
          r_e     <= r_op ? w_ex_s - w_ey_s + BIAS_E
                          : w_ex_s + w_ey_s - BIAS_E;
          r_pack  <= w_sp_res;
          r_pk_of <= w_sp_of;
        end
        S_MUL_IT: begin
          r_prod <= w_prod_nxt;
          r_cnt  <= r_cnt - 1'b1;
        end
        S_DIV_IT: begin
          r_rem <= w_rem_nxt;
          r_quo <= w_quo_nxt;
          r_cnt <= r_cnt - 1'b1;
        end
        S_NORM: begin
          r_sig <= w_n_sig;
          r_g   <= w_n_g;
          r_r   <= w_n_r;
          r_s   <= w_n_s;
          r_e   <= r_e + w_n_adj;
        end
        S_ROUND: begin
          r_pack  <= w_rp_res;
          r_pk_of <= w_rp_of;
        end
        S_DONE: begin
          r_res <= r_pack;
          r_of  <= r_pk_of;
        end
        default: ;
      endcase
    end
  end

  assign busy   = (r_state != S_IDLE);
  assign done   = r_done;
  assign result = r_res;
  assign ofuf   = r_of;

endmodule
